// File: rtl/f2i.sv
// ---------------------------------------------------------------------------
// f2i : bfloat16 -> signed Q8.7 fixed-point converter for the FLOG datapath.
//
// The operand is classified once on acceptance (zero, saturate, normal).
// Normal operands load 1.fract into a 15-bit magnitude register. A shifter
// then moves that register one bit per cycle until the binary point is in
// place, and the result is registered together with a one-cycle valid strobe.
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous, active-low reset
//   valid_f2i_i       operand valid, only looked at while IDLE
//   sgn_i             operand sign
//   exp_i             biased exponent (bias = BIAS)
//   fract_i           stored fraction, hidden leading 1
//   parte_intera      two's-complement integer part
//   parte_frazionaria fractional part, 2^-FRACT_WIDTH per LSB
//   valid_f2i_o       one-cycle result strobe
//   ovf_o             saturation flag, qualified by valid_f2i_o
//   busy_o            high whenever the converter is not IDLE
// ---------------------------------------------------------------------------
package flog_pkg;
  localparam int EXP_WIDTH   = 8;
  localparam int FRACT_WIDTH = 7;
  localparam int BIAS        = 127;
endpackage

module f2i #(
  parameter int EXP_WIDTH   = flog_pkg::EXP_WIDTH,
  parameter int FRACT_WIDTH = flog_pkg::FRACT_WIDTH,
  parameter int BIAS        = flog_pkg::BIAS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_f2i_i,
  input  logic                   sgn_i,
  input  logic [EXP_WIDTH-1:0]   exp_i,
  input  logic [FRACT_WIDTH-1:0] fract_i,
  output logic [EXP_WIDTH-1:0]   parte_intera,
  output logic [FRACT_WIDTH-1:0] parte_frazionaria,
  output logic                   valid_f2i_o,
  output logic                   ovf_o,
  output logic                   busy_o
);

  localparam int W     = EXP_WIDTH + FRACT_WIDTH;
  localparam int CNT_W = $clog2(((EXP_WIDTH > FRACT_WIDTH) ? EXP_WIDTH : FRACT_WIDTH) + 1);

  // Unbiased-exponent thresholds: at or above E_SAT the integer part cannot
  // hold the value; at or below E_ZERO every mantissa bit falls off the LSB.
  localparam logic signed [EXP_WIDTH:0] BIAS_S = (EXP_WIDTH+1)'(BIAS);
  localparam logic signed [EXP_WIDTH:0] E_SAT  = (EXP_WIDTH+1)'(EXP_WIDTH - 1);
  localparam logic signed [EXP_WIDTH:0] E_ZERO = (EXP_WIDTH+1)'(-(FRACT_WIDTH + 1));

  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  typedef enum logic [1:0] {CLS_ZERO, CLS_SAT, CLS_NORM} cls_t;

  state_t state, state_nxt;
  cls_t   cls_q, cls_d;

  logic                        sgn_q;
  logic                        left_q, left_d;
  logic                        ovf_q, ovf_d;
  logic [W-1:0]                mag_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic signed [EXP_WIDTH:0]   e;
  logic [EXP_WIDTH:0]          e_abs;
  logic [W-1:0]                r_norm;

  assign e      = $signed({1'b0, exp_i}) - BIAS_S;
  assign busy_o = (state != IDLE);

  // Classification of the operand currently on the inputs. Only consumed
  // in IDLE when valid_f2i_i is high.
  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    cls_d  = CLS_NORM;
    ovf_d  = 1'b0;
    left_d = 1'b0;
    cnt_d  = '0;
    e_abs  = e[EXP_WIDTH] ? (EXP_WIDTH+1)'(-e) : (EXP_WIDTH+1)'(e);
    if (exp_i == '0 || e <= E_ZERO) begin
      cls_d = CLS_ZERO;
    end else if (exp_i == '1 || e >= E_SAT) begin
      cls_d = CLS_SAT;
      // -2^(EXP_WIDTH-1) is representable exactly: it only hits the rail.
      ovf_d = !(sgn_i && e == E_SAT && fract_i == '0 && exp_i != '1);
    end else begin
      left_d = (e > 0);
      cnt_d  = CNT_W'(e_abs);
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_f2i_i) state_nxt = (cnt_d != '0) ? SHIFT : FINISH;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Two's complement of the aligned magnitude; a -0 wraps back to 0.
  assign r_norm = sgn_q ? (~mag_q + W'(1)) : mag_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cls_q             <= CLS_ZERO;
      sgn_q             <= 1'b0;
      left_q            <= 1'b0;
      ovf_q             <= 1'b0;
      mag_q             <= '0;
      cnt_q             <= '0;
      parte_intera      <= '0;
      parte_frazionaria <= '0;
      valid_f2i_o       <= 1'b0;
      ovf_o             <= 1'b0;
    end else begin
      valid_f2i_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_f2i_i) begin
            sgn_q  <= sgn_i;
            cls_q  <= cls_d;
            ovf_q  <= ovf_d;
            left_q <= left_d;
            cnt_q  <= cnt_d;
            mag_q  <= W'({1'b1, fract_i});
          end
        end
        SHIFT: begin
          mag_q <= left_q ? (mag_q << 1) : (mag_q >> 1);
          cnt_q <= cnt_q - CNT_W'(1);
        end
        FINISH: begin
          valid_f2i_o <= 1'b1;
          ovf_o       <= ovf_q;
          case (cls_q)
            CLS_NORM: {parte_intera, parte_frazionaria} <= r_norm;
            CLS_SAT:  {parte_intera, parte_frazionaria} <= sgn_q ? SAT_NEG : SAT_POS;
            default:  {parte_intera, parte_frazionaria} <= '0;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_f2i.sv
// ---------------------------------------------------------------------------
// tb_f2i : self-checking bench for f2i.
//
// The reference model works on real values: the operand times 128 is
// mant * 2^e with mant = 128 + fract, truncated toward zero, then clamped to
// the 15-bit signed range. Latency follows from the shift count, which is |e|
// for operands that are neither flushed to zero nor saturated.
//
// Timing convention: the acceptance edge closes cycle N, so a strobe in cycle
// N+S+2 is seen S+1 edges after that acceptance edge.
// ---------------------------------------------------------------------------
module tb_f2i;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid_f2i_i = 1'b0;
  logic       sgn_i = 1'b0;
  logic [7:0] exp_i = '0;
  logic [6:0] fract_i = '0;
  logic [7:0] parte_intera;
  logic [6:0] parte_frazionaria;
  logic       valid_f2i_o;
  logic       ovf_o;
  logic       busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  f2i dut (
    .clk               (clk),
    .rst               (rst),
    .valid_f2i_i       (valid_f2i_i),
    .sgn_i             (sgn_i),
    .exp_i             (exp_i),
    .fract_i           (fract_i),
    .parte_intera      (parte_intera),
    .parte_frazionaria (parte_frazionaria),
    .valid_f2i_o       (valid_f2i_o),
    .ovf_o             (ovf_o),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Value-level reference: result word, overflow flag and shift count.
  function automatic void model(input logic s, input logic [7:0] ex, input logic [6:0] fr,
                                output logic [14:0] r, output logic ovf, output int shifts);
    int     e;
    longint mag;
    longint val;
    e      = int'(ex) - 127;
    shifts = 0;
    ovf    = 1'b0;
    if (ex == 8'd0) begin
      r = '0;
    end else if (ex == 8'd255 || e >= 16) begin
      ovf = 1'b1;
      r   = s ? 15'h4000 : 15'h3FFF;
    end else begin
      mag = (e >= 0) ? (longint'(128 + int'(fr)) << e) : (longint'(128 + int'(fr)) >> (-e));
      val = s ? -mag : mag;
      if (val > 16383) begin
        ovf = 1'b1;
        r   = 15'h3FFF;
      end else if (val < -16384) begin
        ovf = 1'b1;
        r   = 15'h4000;
      end else begin
        r = 15'(val);
      end
    end
    if (ex != 8'd0 && ex != 8'd255 && e >= -7 && e <= 6) shifts = (e < 0) ? -e : e;
  endfunction

  task automatic drive(input logic v, input logic s, input logic [7:0] ex, input logic [6:0] fr);
    valid_f2i_i = v;
    sgn_i       = s;
    exp_i       = ex;
    fract_i     = fr;
  endtask

  task automatic test_reset();
    // Valid asserted together with reset must not be accepted.
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'd133, 7'h41);
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({parte_intera, parte_frazionaria, valid_f2i_o, ovf_o, busy_o} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got int=%h frac=%h v=%b ovf=%b busy=%b, want all 0",
               parte_intera, parte_frazionaria, valid_f2i_o, ovf_o, busy_o);
    end
    @(negedge clk);
    valid_f2i_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_accept: busy=%b, want 0", busy_o);
    end
  endtask

  task automatic test_operand(input logic s, input logic [7:0] ex, input logic [6:0] fr,
                              input string name);
    logic [14:0] er;
    logic        eovf;
    int          sh;
    int          lat;
    bit          busy_ok;
    model(s, ex, fr, er, eovf, sh);
    @(negedge clk);
    drive(1'b1, s, ex, fr);
    @(posedge clk);
    #1;
    valid_f2i_i = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (valid_f2i_o !== 1'b1 && lat < 20) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    n_tests++;
    if (lat != sh + 1) begin
      n_fail++;
      $display("FAIL %s latency: strobe at N+%0d, want N+%0d", name, lat + 1, sh + 2);
    end
    n_tests++;
    if ({parte_intera, parte_frazionaria} !== er || ovf_o !== eovf) begin
      n_fail++;
      $display("FAIL %s result: got %h/%h ovf=%b, want %h/%h ovf=%b (s=%b e=%0d f=%h)",
               name, parte_intera, parte_frazionaria, ovf_o, er[14:7], er[6:0], eovf, s, ex, fr);
    end
    n_tests++;
    if (!busy_ok || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy: high-while-working=%b, at-strobe=%b, want 1 and 0", name, busy_ok, busy_o);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (valid_f2i_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s strobe_width: valid still %b one cycle later, want 0", name, valid_f2i_o);
    end
  endtask

  task automatic test_directed();
    test_operand(1'b0, 8'd127, 7'h00, "one");
    test_operand(1'b1, 8'd128, 7'h20, "minus_2p5");
    test_operand(1'b0, 8'd133, 7'h41, "p96p5");
    test_operand(1'b0, 8'd120, 7'h00, "two_m7");
    test_operand(1'b0, 8'd119, 7'h00, "two_m8");
    test_operand(1'b1, 8'd119, 7'h00, "neg_two_m8");
    test_operand(1'b0, 8'd0,   7'h35, "denormal");
    test_operand(1'b0, 8'd134, 7'h7F, "sat_pos");
    test_operand(1'b1, 8'd134, 7'h00, "exact_m128");
    test_operand(1'b1, 8'd134, 7'h01, "sat_neg");
    test_operand(1'b1, 8'd255, 7'h00, "inf_neg");
    test_operand(1'b0, 8'd255, 7'h12, "nan_pos");
    test_operand(1'b1, 8'd121, 7'h55, "neg_small");
  endtask

  task automatic test_random();
    logic [7:0] ex;
    for (int i = 0; i < 40; i++) begin
      ex = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(116, 138));
      test_operand(1'($urandom), ex, 7'($urandom), "random");
    end
  endtask

  task automatic test_ignore_valid();
    int  strobes;
    bit  busy_ok;
    logic [14:0] first;
    strobes = 0;
    busy_ok = 1'b1;
    first   = '0;
    @(negedge clk);
    drive(1'b1, 1'b0, 8'd133, 7'h41);
    @(posedge clk);
    #1;
    valid_f2i_i = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (c == 2) drive(1'b1, 1'b1, 8'd127, 7'h00);
      if (c == 3) valid_f2i_i = 1'b0;
      if (c < 7 && busy_o !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      if (valid_f2i_o === 1'b1) begin
        if (strobes == 0) first = {parte_intera, parte_frazionaria};
        strobes++;
      end
    end
    n_tests++;
    if (strobes != 1 || first !== 15'h3040) begin
      n_fail++;
      $display("FAIL ignore_valid: %0d strobes, first result %h, want 1 strobe of 3040", strobes, first);
    end
    n_tests++;
    if (!busy_ok) begin
      n_fail++;
      $display("FAIL ignore_valid_busy: busy dropped during shift, want held high");
    end
  endtask

  task automatic test_back_to_back();
    logic        s  [5];
    logic [7:0]  ex [5];
    logic [6:0]  fr [5];
    logic [14:0] er;
    logic        eovf;
    int          sh;
    int          lat;
    int          extra;
    for (int k = 0; k < 5; k++) begin
      s[k]  = 1'($urandom);
      ex[k] = 8'($urandom_range(118, 136));
      fr[k] = 7'($urandom);
    end
    @(negedge clk);
    drive(1'b1, s[0], ex[0], fr[0]);
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      model(s[k], ex[k], fr[k], er, eovf, sh);
      lat = 0;
      while (valid_f2i_o !== 1'b1 && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      n_tests++;
      if (lat != sh + 1) begin
        n_fail++;
        $display("FAIL b2b_interval[%0d]: %0d cycles, want %0d", k, lat + 1, sh + 2);
      end
      n_tests++;
      if ({parte_intera, parte_frazionaria} !== er || ovf_o !== eovf) begin
        n_fail++;
        $display("FAIL b2b_result[%0d]: got %h/%h ovf=%b, want %h/%h ovf=%b",
                 k, parte_intera, parte_frazionaria, ovf_o, er[14:7], er[6:0], eovf);
      end
      if (k < 4) drive(1'b1, s[k+1], ex[k+1], fr[k+1]);
      else       valid_f2i_i = 1'b0;
    end
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (valid_f2i_o === 1'b1) extra++;
    end
    n_tests++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL b2b_extra: %0d strobes after the stream ended, want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int strobes;
    @(negedge clk);
    drive(1'b1, 1'b0, 8'd133, 7'h41);
    @(posedge clk);
    #1;
    valid_f2i_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_busy: busy=%b while shifting, want 1", busy_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if ({parte_intera, parte_frazionaria, valid_f2i_o, ovf_o, busy_o} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got int=%h frac=%h v=%b ovf=%b busy=%b, want all 0",
               parte_intera, parte_frazionaria, valid_f2i_o, ovf_o, busy_o);
    end
    @(negedge clk);
    rst = 1'b1;
    strobes = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (valid_f2i_o === 1'b1 || busy_o === 1'b1) strobes++;
    end
    n_tests++;
    if (strobes != 0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: %0d cycles with valid or busy after reset, want 0", strobes);
    end
    test_operand(1'b0, 8'd127, 7'h00, "one_after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_valid();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/f2i.md
# f2i

Converts a bfloat16-format operand (sign, 8-bit biased exponent, 7-bit fraction) into the signed Q8.7 fixed-point pair used by the logarithm datapath: an 8-bit two's-complement `parte_intera` and a 7-bit `parte_frazionaria`. It is the inverse of the fixed-to-float stage, so FLOG results can be returned to the fixed-point domain. The mantissa is aligned by a multi-cycle shifter that moves one bit per cycle, followed by a registered result with a one-cycle valid pulse.

## Interface
- `EXP_WIDTH`, default 8: exponent width, from `flog_pkg`.
- `FRACT_WIDTH`, default 7: stored fraction width, from `flog_pkg`.
- `BIAS`, default 127: exponent bias.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `valid_f2i_i`  in  1  input operand valid; sampled only in IDLE.
- `sgn_i`  in  1  sign of the operand.
- `exp_i`  in  EXP_WIDTH  biased exponent.
- `fract_i`  in  FRACT_WIDTH  fraction, with a hidden leading 1.
- `parte_intera`  out  EXP_WIDTH  two's-complement integer part.
- `parte_frazionaria`  out  FRACT_WIDTH  fractional part, weight 2^-7 per LSB.
- `valid_f2i_o`  out  1  one-cycle result strobe.
- `ovf_o`  out  1  saturation flag; valid when `valid_f2i_o` is high.
- `busy_o`  out  1  high whenever the state is not IDLE.

## Operation
- **Result word.** R = {`parte_intera`, `parte_frazionaria`} is a 15-bit two's-complement value equal to the operand × 128.
- **Unbiased exponent.** e = `exp_i` − 127, computed with 9-bit signed arithmetic.
- **Working register.** `mag` is 15 bits, unsigned.

Classification, done in IDLE on acceptance:
- **Zero.** `exp_i` = 0 (zero or denormal), or e ≤ −8.
  - Result 0, `ovf_o` = 0, S = 0.
- **Saturate.** `exp_i` = 255, or e ≥ 7.
  - `sgn_i` = 0: result 0x7F / 0x7F.
  - `sgn_i` = 1: result 0x80 / 0x00.
  - `ovf_o` = 1, S = 0.
  - Exception: `sgn_i` = 1, e = 7, `fract_i` = 0 is exactly −128. The result is 0x80 / 0x00 with `ovf_o` = 0.
- **Normal.** −7 ≤ e ≤ 6.
  - Load `mag` = {7'b0, 1'b1, `fract_i`}, which represents 1.fract.
  - S = |e|, and the shift direction is left if e > 0, right if e < 0.
  - Bits shifted out on the right are discarded, so the magnitude truncates toward zero.

States:
- **IDLE**
  - If `valid_f2i_i` is high: latch the sign and the classification, load `mag`, set the shift counter `cnt` = S.
  - Go to SHIFT if S > 0, otherwise go to FINISH.
- **SHIFT**
  - Each cycle: shift `mag` by one position in the stored direction and decrement `cnt`.
  - Go to FINISH when `cnt` = 1 on that edge.
- **FINISH**
  - Register the outputs. For normal operands, R = sign ? (~`mag` + 1) : `mag`, truncated to 15 bits; a −0 result naturally becomes 0.
  - Set `valid_f2i_o` and `ovf_o`, then go to IDLE.

Output rules:
- `parte_intera`, `parte_frazionaria` and `ovf_o` hold their value until the next FINISH.
- `valid_f2i_o` is high for exactly one cycle per accepted operand.
- `valid_f2i_i` is ignored whenever the state is not IDLE; there is no queuing.

## Timing
- **Reset.** With `rst` = 0 at a rising edge:
  - State becomes IDLE.
  - `parte_intera`, `parte_frazionaria`, `valid_f2i_o`, `ovf_o` and `busy_o` all become 0.
  - `mag` and `cnt` are cleared.
- **Reset mid-operation.** An in-flight operand is dropped and no `valid_f2i_o` is produced.
- **Latency.** An operand accepted in cycle N has `valid_f2i_o` high in cycle N+S+2, with S ∈ [0,7]. Worst case is 9 cycles.
- **Busy.** `busy_o` is high from cycle N+1 through the FINISH cycle, N+S+1.
- **Back-to-back.** The state is IDLE in the cycle where `valid_f2i_o` is high, so a new operand can be accepted in that same cycle. Sustained throughput is one operand per S+2 cycles.
- **Simultaneous valid and reset.** Reset wins; the operand is not accepted.

## Test plan
- **1.0:** `sgn_i`=0, `exp_i`=127, `fract_i`=0x00 → `parte_intera` 0x01, `parte_frazionaria` 0x00, `ovf_o` 0, valid at N+2.
- **−2.5:** `sgn_i`=1, `exp_i`=128, `fract_i`=0x20 → 0xFD / 0x40, valid at N+3. Also **96.5:** `exp_i`=133, `fract_i`=0x41 → 0x60 / 0x40, valid at N+8.
- **Small values:**
  - 2^-7 (`exp_i`=120, `fract_i`=0) → 0x00 / 0x01, valid at N+9.
  - 2^-8 (`exp_i`=119) → 0 / 0, valid at N+2.
  - −2^-8 → 0 / 0, `ovf_o` 0.
  - `exp_i`=0 → 0 / 0.
- **Saturation:**
  - `sgn_i`=0, `exp_i`=134, `fract_i`=0x7F → 0x7F / 0x7F, `ovf_o` 1.
  - `sgn_i`=1, `exp_i`=134, `fract_i`=0 → 0x80 / 0x00, `ovf_o` 0.
  - `sgn_i`=1, `exp_i`=255 → 0x80 / 0x00, `ovf_o` 1.
- **Handshake:**
  - A second `valid_f2i_i` pulse during SHIFT is ignored: exactly one `valid_f2i_o` is produced and `busy_o` stays high.
  - `valid_f2i_i` held high continuously gives one result every S+2 cycles, with no lost or duplicated strobes.
- **Reset:**
  - Drive `rst`=0 during SHIFT of a 96.5 operand → all outputs 0 on the next edge, no valid pulse, IDLE afterward.
  - A subsequent 1.0 operand then converts correctly.
